// File: rtl/noc_credit_link_pipe_pkg.sv
// Shared defaults for the credit-based NoC link pipeline.
package common_pkg;

  localparam int DEFAULT_VC_W = 2;
  localparam int DEFAULT_A_W  = 6;
  localparam int DEFAULT_D_W  = 32;

endpackage : common_pkg

// File: rtl/noc_credit_link_stage.sv
// One register stage of the link: flit forward, credit grant backward.
// Optional macro NOC_PIPE_PKT_GATE_EN clock-enables the packet register on a valid vc_target.
module noc_credit_link_stage
  import common_pkg::*;
#(
  parameter int VC_W = DEFAULT_VC_W,
  parameter int A_W  = DEFAULT_A_W,
  parameter int D_W  = DEFAULT_D_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VC_W-1:0]      from_vc_target,
  input  logic [A_W+D_W-1:0]   from_packet,
  output logic [VC_W-1:0]      from_vc_credit_gnt,
  output logic [VC_W-1:0]      to_vc_target,
  output logic [A_W+D_W-1:0]   to_packet,
  input  logic [VC_W-1:0]      to_vc_credit_gnt
);

  localparam int PKT_W = A_W + D_W;

  logic [VC_W-1:0]  vc_target_p0;
  logic [PKT_W-1:0] packet_p0;
  logic [VC_W-1:0]  credit_gnt_p0;

  // stage p0: forward flit and backward credit registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vc_target_p0  <= '0;
      credit_gnt_p0 <= '0;
    end else begin
      vc_target_p0  <= from_vc_target;
      credit_gnt_p0 <= to_vc_credit_gnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      packet_p0 <= '0;
    end else begin
`ifdef NOC_PIPE_PKT_GATE_EN
      if (|from_vc_target) packet_p0 <= from_packet;
`else
      packet_p0 <= from_packet;
`endif
    end
  end

  assign to_vc_target       = vc_target_p0;
  assign to_packet          = packet_p0;
  assign from_vc_credit_gnt = credit_gnt_p0;

endmodule : noc_credit_link_stage

// File: rtl/noc_credit_link_pipe.sv
// Timing-closure pipe for one credit-based NoC link: LATENCY stages each way, 0 = wire.
// Optional macro NOC_PIPE_PKT_GATE_EN (see noc_credit_link_stage) gates packet registers.
module noc_credit_link_pipe
  import common_pkg::*;
#(
  parameter int VC_W    = DEFAULT_VC_W,
  parameter int A_W     = DEFAULT_A_W,
  parameter int D_W     = DEFAULT_D_W,
  parameter int LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VC_W-1:0]      from_vc_target,
  input  logic [A_W+D_W-1:0]   from_packet,
  output logic [VC_W-1:0]      from_vc_credit_gnt,
  output logic [VC_W-1:0]      to_vc_target,
  output logic [A_W+D_W-1:0]   to_packet,
  input  logic [VC_W-1:0]      to_vc_credit_gnt
);

  localparam int PKT_W = A_W + D_W;

  generate
    if (LATENCY == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst     = clk ^ rst;
      assign to_vc_target       = from_vc_target;
      assign to_packet          = from_packet;
      assign from_vc_credit_gnt = to_vc_credit_gnt;
    end else begin : g_pipe
      // index 0 faces the upstream transmitter, index LATENCY the downstream receiver
      logic [VC_W-1:0]  vc_fwd  [LATENCY+1];
      logic [PKT_W-1:0] pkt_fwd [LATENCY+1];
      logic [VC_W-1:0]  gnt_bwd [LATENCY+1];

      assign vc_fwd[0]          = from_vc_target;
      assign pkt_fwd[0]         = from_packet;
      assign gnt_bwd[LATENCY]   = to_vc_credit_gnt;
      assign to_vc_target       = vc_fwd[LATENCY];
      assign to_packet          = pkt_fwd[LATENCY];
      assign from_vc_credit_gnt = gnt_bwd[0];

      for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        noc_credit_link_stage #(
          .VC_W (VC_W),
          .A_W  (A_W),
          .D_W  (D_W)
        ) u_stage (
          .clk                (clk),
          .rst                (rst),
          .from_vc_target     (vc_fwd[i]),
          .from_packet        (pkt_fwd[i]),
          .from_vc_credit_gnt (gnt_bwd[i]),
          .to_vc_target       (vc_fwd[i+1]),
          .to_packet          (pkt_fwd[i+1]),
          .to_vc_credit_gnt   (gnt_bwd[i+1])
        );
      end
    end
  endgenerate

endmodule : noc_credit_link_pipe

// File: tb/tb_noc_credit_link_pipe.sv
// Scoreboard bench for noc_credit_link_pipe at LATENCY 0, 1, 2 and 3 sharing one stimulus.
module tb_noc_credit_link_pipe;

  localparam int VC_W  = 2;
  localparam int A_W   = 6;
  localparam int D_W   = 32;
  localparam int PKT_W = A_W + D_W;

  typedef struct {
    logic [VC_W-1:0]  vc;
    logic [PKT_W-1:0] pkt;
    int               cyc;
  } flit_t;

  typedef struct {
    logic [VC_W-1:0] gnt;
    int              cyc;
  } cred_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [VC_W-1:0]  from_vc;
  logic [PKT_W-1:0] from_pkt;
  logic [VC_W-1:0]  to_gnt;

  logic [VC_W-1:0]  l0_vc, l1_vc, l2_vc, l3_vc;
  logic [PKT_W-1:0] l0_pkt, l1_pkt, l2_pkt, l3_pkt;
  logic [VC_W-1:0]  l0_gnt, l1_gnt, l2_gnt, l3_gnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int credit_total = 0;
  flit_t fq[$];
  cred_t cq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  noc_credit_link_pipe #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .from_vc_target(from_vc), .from_packet(from_pkt),
    .from_vc_credit_gnt(l0_gnt), .to_vc_target(l0_vc), .to_packet(l0_pkt),
    .to_vc_credit_gnt(to_gnt));
  noc_credit_link_pipe #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .from_vc_target(from_vc), .from_packet(from_pkt),
    .from_vc_credit_gnt(l1_gnt), .to_vc_target(l1_vc), .to_packet(l1_pkt),
    .to_vc_credit_gnt(to_gnt));
  noc_credit_link_pipe #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .from_vc_target(from_vc), .from_packet(from_pkt),
    .from_vc_credit_gnt(l2_gnt), .to_vc_target(l2_vc), .to_packet(l2_pkt),
    .to_vc_credit_gnt(to_gnt));
  noc_credit_link_pipe #(.VC_W(VC_W), .A_W(A_W), .D_W(D_W), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .from_vc_target(from_vc), .from_packet(from_pkt),
    .from_vc_credit_gnt(l3_gnt), .to_vc_target(l3_vc), .to_packet(l3_pkt),
    .to_vc_credit_gnt(to_gnt));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs; tracked items are expected on the LATENCY=3 pipe 3 cycles later.
  task automatic issue(input logic [VC_W-1:0] vc, input logic [PKT_W-1:0] pkt,
                       input logic [VC_W-1:0] gnt, input bit track);
    flit_t f;
    cred_t c;
    from_vc  = vc;
    from_pkt = pkt;
    to_gnt   = gnt;
    if (track && vc != '0) begin
      f.vc = vc; f.pkt = pkt; f.cyc = cyc + 3;
      fq.push_back(f);
    end
    if (track && gnt != '0) begin
      c.gnt = gnt; c.cyc = cyc + 3;
      cq.push_back(c);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor for the LATENCY=3 instance.
  always @(negedge clk) begin
    if (rst) begin
      if (l3_vc != '0) begin
        if (fq.size() == 0) begin
          check("l3_unexpected_flit", {62'b0, l3_vc}, 64'h0);
        end else begin
          flit_t f;
          f = fq.pop_front();
          check("l3_flit_vc", {62'b0, l3_vc}, {62'b0, f.vc});
          check("l3_flit_pkt", {26'b0, l3_pkt}, {26'b0, f.pkt});
          check("l3_flit_cycle", 64'(cyc), 64'(f.cyc));
        end
      end
      if (l3_gnt != '0) begin
        credit_total += $countones(l3_gnt);
        if (cq.size() == 0) begin
          check("l3_unexpected_credit", {62'b0, l3_gnt}, 64'h0);
        end else begin
          cred_t c;
          c = cq.pop_front();
          check("l3_credit_gnt", {62'b0, l3_gnt}, {62'b0, c.gnt});
          check("l3_credit_cycle", 64'(cyc), 64'(c.cyc));
        end
      end
    end
  end

  initial begin
    // held in reset with live inputs
    from_vc  = 2'b01;
    from_pkt = 38'h05_DEAD_BEEF;
    to_gnt   = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("rst_l1_vc", {62'b0, l1_vc}, 64'h0);
    check("rst_l1_pkt", {26'b0, l1_pkt}, 64'h0);
    check("rst_l1_gnt", {62'b0, l1_gnt}, 64'h0);
    check("rst_l2_vc", {62'b0, l2_vc}, 64'h0);
    check("rst_l3_pkt", {26'b0, l3_pkt}, 64'h0);
    check("rst_l3_gnt", {62'b0, l3_gnt}, 64'h0);
    check("rst_l0_vc", {62'b0, l0_vc}, 64'h1);
    check("rst_l0_pkt", {26'b0, l0_pkt}, 64'h05_DEAD_BEEF);

    // release: one flit captured on the following edge
    rst = 1'b1;
    #1;
    check("rel_l1_vc_before_edge", {62'b0, l1_vc}, 64'h0);
    issue(2'b01, 38'h05_DEAD_BEEF, 2'b11, 1'b1);
    check("rel_l1_vc", {62'b0, l1_vc}, 64'h1);
    check("rel_l1_pkt", {26'b0, l1_pkt}, 64'h05_DEAD_BEEF);
    check("rel_l1_gnt", {62'b0, l1_gnt}, 64'h3);
    check("rel_l2_vc", {62'b0, l2_vc}, 64'h0);
    issue(2'b00, 38'h0, 2'b00, 1'b1);
    check("rel_l1_vc_idle", {62'b0, l1_vc}, 64'h0);
    check("rel_l2_vc", {62'b0, l2_vc}, 64'h1);
    repeat (3) issue(2'b00, 38'h0, 2'b00, 1'b1);

    // single flit and credit, latency sweep
    issue(2'b10, 38'h21_0000_0007, 2'b01, 1'b1);
    check("swp_l1_vc", {62'b0, l1_vc}, 64'h2);
    check("swp_l1_pkt", {26'b0, l1_pkt}, 64'h21_0000_0007);
    check("swp_l1_gnt", {62'b0, l1_gnt}, 64'h1);
    issue(2'b00, 38'h0, 2'b00, 1'b1);
    check("swp_l1_vc_idle", {62'b0, l1_vc}, 64'h0);
    check("swp_l2_vc", {62'b0, l2_vc}, 64'h2);
    check("swp_l2_pkt", {26'b0, l2_pkt}, 64'h21_0000_0007);
    check("swp_l2_gnt", {62'b0, l2_gnt}, 64'h1);
    repeat (3) issue(2'b00, 38'h0, 2'b00, 1'b1);

    // back-to-back flits, 4 cycles of double credits
    for (int i = 0; i < 8; i++) begin
      issue((i % 2 == 1) ? 2'b10 : 2'b01, {6'h03, 32'(i)}, (i < 4) ? 2'b11 : 2'b00, 1'b1);
    end
    repeat (4) issue(2'b00, 38'h0, 2'b00, 1'b1);

    // combinational bypass
    #2;
    from_vc = 2'b10; from_pkt = 38'h3F_1234_5678; to_gnt = 2'b01;
    #1;
    check("l0_vc_a", {62'b0, l0_vc}, 64'h2);
    check("l0_pkt_a", {26'b0, l0_pkt}, 64'h3F_1234_5678);
    check("l0_gnt_a", {62'b0, l0_gnt}, 64'h1);
    from_vc = 2'b11; from_pkt = 38'h01_0000_0001; to_gnt = 2'b10;
    #1;
    check("l0_vc_b", {62'b0, l0_vc}, 64'h3);
    check("l0_pkt_b", {26'b0, l0_pkt}, 64'h01_0000_0001);
    check("l0_gnt_b", {62'b0, l0_gnt}, 64'h2);
    from_vc = '0; from_pkt = '0; to_gnt = '0;
    @(posedge clk);
    #1;

    // packet behaviour on idle cycles
    issue(2'b01, 38'h00_0000_00AA, 2'b00, 1'b1);
    issue(2'b00, 38'h00_0000_0055, 2'b00, 1'b1);
`ifdef NOC_PIPE_PKT_GATE_EN
    check("gate_l1_pkt_idle", {26'b0, l1_pkt}, 64'hAA);
`else
    check("gate_l1_pkt_idle", {26'b0, l1_pkt}, 64'h55);
`endif
    issue(2'b00, 38'h00_0000_0055, 2'b00, 1'b1);
`ifdef NOC_PIPE_PKT_GATE_EN
    check("gate_l2_pkt_idle", {26'b0, l2_pkt}, 64'hAA);
`else
    check("gate_l2_pkt_idle", {26'b0, l2_pkt}, 64'h55);
`endif
    repeat (5) issue(2'b00, 38'h0, 2'b00, 1'b1);

    // asynchronous reset with flits in flight
    issue(2'b01, 38'h00_0000_0011, 2'b00, 1'b0);
    issue(2'b10, 38'h00_0000_0022, 2'b00, 1'b0);
    from_vc = '0; from_pkt = '0; to_gnt = '0;
    check("ar_l2_vc_before", {62'b0, l2_vc}, 64'h1);
    #3;
    rst = 1'b0;
    #1;
    check("ar_l2_vc", {62'b0, l2_vc}, 64'h0);
    check("ar_l2_pkt", {26'b0, l2_pkt}, 64'h0);
    check("ar_l1_vc", {62'b0, l1_vc}, 64'h0);
    check("ar_l1_pkt", {26'b0, l1_pkt}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("ar_l2_vc_after", {62'b0, l2_vc}, 64'h0);
      check("ar_l3_vc_after", {62'b0, l3_vc}, 64'h0);
    end

    check("flit_queue_empty", 64'(fq.size()), 64'h0);
    check("credit_queue_empty", 64'(cq.size()), 64'h0);
    check("credit_total", 64'(credit_total), 64'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_noc_credit_link_pipe
